// File: rtl/op_stack_pkg.sv
// Shared encodings for the operator stack: operator/data widths and stack commands.
// Latency: none (types and constants only).
// Backpressure: none; the stack commands carry no handshake.
package op_stack_pkg;

  // Operator code width; this is also the width of the shared data bus.
  localparam int CO_N = 8;
  // Data word width and the value shown on the bus while the stack is empty.
  localparam int CD_N = 8;
  localparam logic [CD_N-1:0] CD_0 = '0;

  // Stack command encoding, shared with the data stack.
  localparam int SC_N = 2;
  typedef enum logic [SC_N-1:0] {
    SC_NON = 2'd0,
    SC_PUS = 2'd1,
    SC_POP = 2'd2,
    SC_CLR = 2'd3
  } sc_e;

endpackage

// File: rtl/op_stack_if.sv
// Command and status bundle between the controller's stack decoder and the operator stack.
// Latency: none; this is wiring only.
// Backpressure: none; one command per cycle, and the flags report overflow or underflow after the fact.
interface op_stack_if
  import op_stack_pkg::*;
#(
  parameter int AW = 4
) ();

  sc_e          cmd;
  logic         empty;
  logic         full;
  logic [AW:0]  count;
  logic         err;

  // The controller side issues commands and observes the flags.
  modport master (output cmd, input empty, full, count, err);
  // The stack side consumes commands and reports the flags.
  modport slave  (input cmd, output empty, full, count, err);

endinterface

// File: rtl/op_stack_lifo_core.sv
// Generic synchronous LIFO: registered count, memory array and a sticky error flag.
// Latency: one cycle from a push or pop to the updated top; flags come straight from the count register.
// Backpressure: none; a push while full or a pop while empty is dropped and sets err.
module lifo_core #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 16,
  parameter int               AW        = 4,
  parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             err
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      cnt_q;
  logic             err_q;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [AW:0]      cnt_m1;

  // The write address is the low bits of count; a push while full is blocked,
  // so the address never wraps onto entry 0.
  assign wr_addr = cnt_q[AW-1:0];
  assign cnt_m1  = cnt_q - 1'b1;
  assign rd_addr = cnt_m1[AW-1:0];

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  assign err   = err_q;
  assign top   = empty ? EMPTY_VAL : mem[rd_addr];

  // Count and sticky error update; reset wins over any command in the same cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (push) begin
      if (full) err_q <= 1'b1;
      else      cnt_q <= cnt_q + 1'b1;
    end else if (pop) begin
      if (empty) err_q <= 1'b1;
      else       cnt_q <= cnt_q - 1'b1;
    end
  end

  // Memory write; contents are left alone by reset, but a push during reset is dropped.
  always_ff @(posedge Clock) begin
    if (Reset && push && !full) begin
      mem[wr_addr] <= din;
    end
  end

endmodule

// File: rtl/op_stack.sv
// Operator stack: decodes the stack command and shares one bidirectional bus with the decoder.
// Latency: a pushed value becomes top one cycle later; the bus shows top combinationally from registered state.
// Backpressure: none; overflow and underflow set the sticky err flag instead of stalling.
module op_stack
  import op_stack_pkg::*;
#(
  parameter int WIDTH = CO_N,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  op_stack_if.slave        bus,
  inout  wire  [WIDTH-1:0] data
);

  logic             push;
  logic             pop;
  logic             clr;
  logic [WIDTH-1:0] top;

  // Command decode; any encoding other than push, pop or clear is a no-op.
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
    case (bus.cmd)
      SC_PUS:  push = 1'b1;
      SC_POP:  pop  = 1'b1;
      SC_CLR:  clr  = 1'b1;
      default: ;
    endcase
  end

  lifo_core #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW),
    .EMPTY_VAL (WIDTH'(CD_0))
  ) u_core (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .clr   (clr),
    .din   (data),
    .top   (top),
    .empty (bus.empty),
    .full  (bus.full),
    .count (bus.count),
    .err   (bus.err)
  );

  // The decoder owns the bus only during a push; at all other times, reset included, this block drives top.
  assign data = push ? {WIDTH{1'bz}} : top;

endmodule
